// File: rtl/coin_pkg.sv
// Shared sizes, slot record and bounds helper for the coin sprite renderer.
package coin_pkg;
  localparam int unsigned SPRITE_W = 16;
  localparam int unsigned SHEET_W  = 128;
  localparam int unsigned ADDR_W   = 11;

  typedef struct packed {
    logic       en;
    logic [9:0] x;
    logic [9:0] y;
  } coin_slot_t;

  // 11-bit compare so sprites placed near 1023 never wrap their right/bottom edge
  function automatic logic in_span(input logic [9:0] p, input logic [9:0] o);
    return ({1'b0, p} >= {1'b0, o}) && ({1'b0, p} < ({1'b0, o} + 11'(SPRITE_W)));
  endfunction
endpackage

// File: rtl/coin_anim_seq.sv
// Spin animation sequencer: advances the sprite-sheet frame every FRAME_DIV video frames.
module coin_anim_seq #(
  parameter int unsigned FRAME_DIV  = 6,
  parameter int unsigned NUM_FRAMES = 8
) (
  input  logic       vga_clk_i,
  input  logic       reset_i,
  input  logic       frame_start_i,
  output logic [2:0] frame_o
);
  localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       frame_q, frame_d;

  always_comb begin
    div_d   = div_q;
    frame_d = frame_q;
    if (frame_start_i) begin
      if (32'(div_q) == FRAME_DIV - 1) begin
        div_d   = '0;
        frame_d = (frame_q + 3'd1) & 3'(NUM_FRAMES - 1);
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge vga_clk_i) begin
    if (reset_i) begin
      div_q   <= '0;
      frame_q <= '0;
    end else begin
      div_q   <= div_d;
      frame_q <= frame_d;
    end
  end

  assign frame_o = frame_q;
endmodule

// File: rtl/coin_render_ctrl.sv
// Coin sprite renderer: double-buffered slots, per-pixel priority pick and
// a 3-stage pipeline around the shared sprite-sheet ROM.
module coin_render_ctrl
  import coin_pkg::*;
#(
  parameter  int unsigned NUM_COINS  = 8,
  parameter  int unsigned FRAME_DIV  = 6,
  parameter  int unsigned NUM_FRAMES = 8,
  localparam int unsigned IDX_W      = $clog2(NUM_COINS),
  localparam int unsigned CNT_W      = $clog2(NUM_COINS + 1)
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic              coin_we,
  input  logic [IDX_W-1:0]  coin_idx,
  input  logic [9:0]        coin_x,
  input  logic [9:0]        coin_y,
  input  logic              coin_en,
  input  logic              collect_req,
  output logic              collect_ack,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [7:0]        rom_q,
  output logic              coin_on,
  output logic [7:0]        pixel_index,
  output logic [CNT_W-1:0]  coins_active
);
  coin_slot_t pend_q [NUM_COINS];
  coin_slot_t pend_d [NUM_COINS];
  coin_slot_t act_q  [NUM_COINS];
  coin_slot_t act_d  [NUM_COINS];

  logic              ack_q, ack_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hit_q, hit_d, hit_qq;
  logic              blank_q, blank_qq;
  logic              on_q, on_d;
  logic [7:0]        pix_q, pix_d;
  logic [2:0]        frame;
  logic              idx_ok;
  logic [9:0]        win_x, win_y;
  logic [3:0]        lx, ly;

  coin_anim_seq #(
    .FRAME_DIV (FRAME_DIV),
    .NUM_FRAMES(NUM_FRAMES)
  ) u_anim (
    .vga_clk_i    (vga_clk),
    .reset_i      (reset),
    .frame_start_i(frame_start),
    .frame_o      (frame)
  );

  assign idx_ok = 32'(coin_idx) < NUM_COINS;

  // Commit copies the pre-edge pending slot; collect then wins on active,
  // and a same-cycle write wins on pending.
  always_comb begin
    for (int unsigned i = 0; i < NUM_COINS; i++) begin
      pend_d[i] = pend_q[i];
      act_d[i]  = frame_start ? pend_q[i] : act_q[i];
      if (collect_req && idx_ok && 32'(coin_idx) == i) begin
        act_d[i].en  = 1'b0;
        pend_d[i].en = 1'b0;
      end
      if (coin_we && idx_ok && 32'(coin_idx) == i) begin
        pend_d[i] = '{en: coin_en, x: coin_x, y: coin_y};
      end
    end
    ack_d = collect_req && idx_ok;
  end

  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < NUM_COINS; i++) begin
      cnt_d = cnt_d + CNT_W'(act_q[i].en);
    end
  end

  always_comb begin
    hit_d = 1'b0;
    win_x = '0;
    win_y = '0;
    for (int unsigned i = 0; i < NUM_COINS; i++) begin
      if (!hit_d && act_q[i].en && in_span(DrawX, act_q[i].x) && in_span(DrawY, act_q[i].y)) begin
        hit_d = 1'b1;
        win_x = act_q[i].x;
        win_y = act_q[i].y;
      end
    end
    lx     = 4'(DrawX - win_x);
    ly     = 4'(DrawY - win_y);
    addr_d = hit_d ? {ly, frame, lx} : addr_q;
  end

  always_comb begin
    on_d  = hit_qq && blank_qq && (rom_q != 8'd0);
    pix_d = on_d ? rom_q : 8'd0;
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_COINS; i++) begin
        pend_q[i] <= '0;
        act_q[i]  <= '0;
      end
      ack_q    <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      hit_q    <= 1'b0;
      hit_qq   <= 1'b0;
      blank_q  <= 1'b0;
      blank_qq <= 1'b0;
      on_q     <= 1'b0;
      pix_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_COINS; i++) begin
        pend_q[i] <= pend_d[i];
        act_q[i]  <= act_d[i];
      end
      ack_q    <= ack_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      hit_q    <= hit_d;
      hit_qq   <= hit_q;
      blank_q  <= blank;
      blank_qq <= blank_q;
      on_q     <= on_d;
      pix_q    <= pix_d;
    end
  end

  assign collect_ack  = ack_q;
  assign coins_active = cnt_q;
  assign rom_address  = addr_q;
  assign coin_on      = on_q;
  assign pixel_index  = pix_q;
endmodule

// File: tb/tb_coin_render_ctrl.sv
// Self-checking bench for coin_render_ctrl: directed vector table, corner sequences,
// then randomized traffic against a behavioural slot/animation model.
module tb_coin_render_ctrl;
  logic        vga_clk = 1'b0;
  logic        reset;
  logic [9:0]  DrawX, DrawY;
  logic        blank, frame_start, coin_we, coin_en, collect_req;
  logic [2:0]  coin_idx;
  logic [9:0]  coin_x, coin_y;
  logic        collect_ack;
  logic [10:0] rom_address;
  logic [7:0]  rom_q;
  logic        coin_on;
  logic [7:0]  pixel_index;
  logic [3:0]  coins_active;

  logic [7:0]  rom [2048];
  int          tests = 0;
  int          fails = 0;

  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) rom_q <= rom[rom_address];

  coin_render_ctrl #(.NUM_COINS(8), .FRAME_DIV(6), .NUM_FRAMES(8)) dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .coin_we(coin_we), .coin_idx(coin_idx), .coin_x(coin_x),
    .coin_y(coin_y), .coin_en(coin_en), .collect_req(collect_req), .collect_ack(collect_ack),
    .rom_address(rom_address), .rom_q(rom_q), .coin_on(coin_on), .pixel_index(pixel_index),
    .coins_active(coins_active)
  );

  typedef struct {
    int dx, dy;
    bit bl;
    bit plant;
    int rom_val;
    int exp_addr;
    bit exp_on;
    int exp_pix;
  } vec_t;

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic idle_inputs();
    DrawX = '0; DrawY = '0; blank = 1'b0; frame_start = 1'b0; coin_we = 1'b0;
    coin_idx = '0; coin_x = '0; coin_y = '0; coin_en = 1'b0; collect_req = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge vga_clk);
    reset = 1'b0;
  endtask

  task automatic write_slot(input int idx, input int x, input int y, input bit en);
    coin_we = 1'b1; coin_idx = 3'(idx); coin_x = 10'(x); coin_y = 10'(y); coin_en = en;
    @(negedge vga_clk);
    coin_we = 1'b0;
  endtask

  task automatic pulse_fs(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      @(negedge vga_clk);
      frame_start = 1'b0;
      @(negedge vga_clk);
    end
  endtask

  // Address is visible one edge after the pixel, colour three edges after.
  task automatic pixel(input string tag, input int dx, input int dy, input bit bl,
                       input int ea, input bit eon, input int epix);
    DrawX = 10'(dx); DrawY = 10'(dy); blank = bl;
    @(negedge vga_clk);
    if (ea >= 0) chk({tag, "_addr"}, rom_address, ea);
    @(negedge vga_clk);
    @(negedge vga_clk);
    chk({tag, "_on"}, coin_on, eon);
    chk({tag, "_pix"}, pixel_index, epix);
  endtask

  // Behavioural model state for the random phase
  int m_aen[8], m_ax[8], m_ay[8], m_pen[8], m_px[8], m_py[8];
  int m_div, m_frame, m_addr, m_cnt;
  bit m_ack;
  bit q_on[$];
  int q_pix[$];

  function automatic int rcoord(input bit hi);
    return hi ? int'($urandom_range(1005, 1023)) : int'($urandom_range(0, 40));
  endfunction

  initial begin
    vec_t tbl[7];
    bit seen_on;

    for (int a = 0; a < 2048; a++) rom[a] = 8'((a % 255) + 1);

    // Reset state
    do_reset();
    chk("rst_on", coin_on, 0);
    chk("rst_pix", pixel_index, 0);
    chk("rst_addr", rom_address, 0);
    chk("rst_ack", collect_ack, 0);
    chk("rst_cnt", coins_active, 0);

    // Pending write without commit never draws
    write_slot(0, 100, 50, 1'b1);
    seen_on = 1'b0;
    blank = 1'b1;
    for (int y = 46; y < 70; y++) begin
      for (int x = 96; x < 120; x++) begin
        DrawX = 10'(x); DrawY = 10'(y);
        @(negedge vga_clk);
        if (coin_on) seen_on = 1'b1;
      end
    end
    repeat (3) begin
      @(negedge vga_clk);
      if (coin_on) seen_on = 1'b1;
    end
    chk("nocommit_on", seen_on, 0);
    chk("nocommit_cnt", coins_active, 0);

    // Commit, then the vector table (frame 0)
    pulse_fs(1);
    tbl[0] = '{105, 53, 1, 1, 8'h12, 389, 1, 8'h12};
    tbl[1] = '{100, 50, 1, 1, 0, 0, 0, 0};
    tbl[2] = '{105, 53, 0, 0, 0, 389, 0, 0};
    tbl[3] = '{99, 50, 1, 0, 0, 389, 0, 0};
    tbl[4] = '{115, 65, 1, 1, 8'hA7, 1935, 1, 8'hA7};
    tbl[5] = '{116, 50, 1, 0, 0, 1935, 0, 0};
    tbl[6] = '{100, 66, 1, 0, 0, 1935, 0, 0};
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].plant) rom[tbl[i].exp_addr] = 8'(tbl[i].rom_val);
      pixel($sformatf("tbl%0d", i), tbl[i].dx, tbl[i].dy, tbl[i].bl,
            tbl[i].exp_addr, tbl[i].exp_on, tbl[i].exp_pix);
    end
    chk("tbl_cnt", coins_active, 1);

    // Overlap priority and mid-frame collect
    do_reset();
    write_slot(2, 200, 200, 1'b1);
    write_slot(5, 195, 195, 1'b1);
    pulse_fs(1);
    pixel("ovl2", 205, 207, 1'b1, 901, 1'b1, 137);
    chk("ovl_cnt2", coins_active, 2);
    coin_idx = 3'd2; collect_req = 1'b1;
    @(negedge vga_clk);
    collect_req = 1'b0;
    chk("col_ack1", collect_ack, 1);
    @(negedge vga_clk);
    chk("col_ack0", collect_ack, 0);
    chk("col_cnt1", coins_active, 1);
    pixel("ovl5", 205, 207, 1'b1, 1546, 1'b1, 17);

    // Animation divider and wrap
    do_reset();
    write_slot(0, 100, 50, 1'b1);
    pulse_fs(12);
    pixel("anim12", 105, 53, 1'b1, 421, 1'b1, 167);
    pulse_fs(35);
    pixel("anim47", 105, 53, 1'b1, 501, 1'b1, 247);
    pulse_fs(1);
    pixel("anim48", 105, 53, 1'b1, 389, 1'b1, 8'h12);

    // Collect and commit of the same slot in one cycle
    write_slot(3, 300, 300, 1'b1);
    coin_idx = 3'd3; collect_req = 1'b1; frame_start = 1'b1;
    @(negedge vga_clk);
    collect_req = 1'b0; frame_start = 1'b0;
    chk("cfs_ack", collect_ack, 1);
    pixel("cfs1", 305, 305, 1'b1, -1, 1'b0, 0);
    pulse_fs(1);
    pixel("cfs2", 305, 305, 1'b1, -1, 1'b0, 0);
    chk("cfs_cnt", coins_active, 1);

    // Reset mid-line while drawing
    DrawX = 10'd105; DrawY = 10'd53; blank = 1'b1;
    repeat (3) @(negedge vga_clk);
    chk("mid_on_pre", coin_on, 1);
    reset = 1'b1;
    @(negedge vga_clk);
    chk("mid_on", coin_on, 0);
    chk("mid_pix", pixel_index, 0);
    chk("mid_addr", rom_address, 0);
    chk("mid_cnt", coins_active, 0);

    // Randomized phase against the model
    for (int a = 0; a < 2048; a++)
      rom[a] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
    idle_inputs();
    @(negedge vga_clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_aen[i] = 0; m_ax[i] = 0; m_ay[i] = 0; m_pen[i] = 0; m_px[i] = 0; m_py[i] = 0;
    end
    m_div = 0; m_frame = 0; m_addr = 0; m_cnt = 0; m_ack = 1'b0;
    repeat (3) begin q_on.push_back(1'b0); q_pix.push_back(0); end

    for (int step = 0; step < 3000; step++) begin
      int dx, dy, win, idx, addr;
      bit hi, on;
      int n_aen[8], n_pen[8], n_px[8], n_py[8];

      chk("rnd_on", coin_on, q_on.pop_front());
      chk("rnd_pix", pixel_index, q_pix.pop_front());
      chk("rnd_addr", rom_address, m_addr);
      chk("rnd_ack", collect_ack, m_ack);
      chk("rnd_cnt", coins_active, m_cnt);

      hi = ($urandom_range(0, 3) == 0);
      dx = hi ? int'($urandom_range(995, 1023)) : int'($urandom_range(0, 60));
      dy = hi ? int'($urandom_range(995, 1023)) : int'($urandom_range(0, 60));
      idx = int'($urandom_range(0, 7));
      DrawX = 10'(dx); DrawY = 10'(dy);
      blank = ($urandom_range(0, 3) != 0);
      frame_start = ($urandom_range(0, 9) == 0);
      coin_we = ($urandom_range(0, 3) == 0);
      collect_req = ($urandom_range(0, 15) == 0);
      coin_idx = 3'(idx);
      hi = ($urandom_range(0, 3) == 0);
      coin_x = 10'(rcoord(hi));
      coin_y = 10'(rcoord(hi));
      coin_en = ($urandom_range(0, 4) != 0);

      win = -1;
      for (int i = 7; i >= 0; i--)
        if (m_aen[i] != 0 && dx >= m_ax[i] && dx < m_ax[i] + 16 &&
            dy >= m_ay[i] && dy < m_ay[i] + 16) win = i;
      if (win >= 0) begin
        addr = (dy - m_ay[win]) * 128 + m_frame * 16 + (dx - m_ax[win]);
        m_addr = addr;
        on = blank && (rom[addr] != 0);
        q_on.push_back(on);
        q_pix.push_back(on ? int'(rom[addr]) : 0);
      end else begin
        q_on.push_back(1'b0);
        q_pix.push_back(0);
      end

      m_cnt = 0;
      for (int i = 0; i < 8; i++) m_cnt += m_aen[i];
      m_ack = collect_req;
      for (int i = 0; i < 8; i++) begin
        n_aen[i] = frame_start ? m_pen[i] : m_aen[i];
        n_pen[i] = m_pen[i]; n_px[i] = m_px[i]; n_py[i] = m_py[i];
        if (frame_start) begin m_ax[i] = m_px[i]; m_ay[i] = m_py[i]; end
      end
      if (collect_req) begin n_aen[idx] = 0; n_pen[idx] = 0; end
      if (coin_we) begin
        n_pen[idx] = int'(coin_en); n_px[idx] = int'(coin_x); n_py[idx] = int'(coin_y);
      end
      for (int i = 0; i < 8; i++) begin
        m_aen[i] = n_aen[i]; m_pen[i] = n_pen[i]; m_px[i] = n_px[i]; m_py[i] = n_py[i];
      end
      if (frame_start) begin
        m_div++;
        if (m_div == 6) begin m_div = 0; m_frame = (m_frame + 1) % 8; end
      end
      @(negedge vga_clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
